// File: rtl/frame_flip_scheduler.sv
// Double-buffer flip scheduler: grants the back buffer to the loader and swaps banks at frame boundaries.
// Latency 1 cycle (all outputs registered); overrun loaded pulses are dropped. Optional stats via FLIP_STATS_EN.
// Backpressure: ready deasserts while a loaded frame waits for its swap.
module frame_flip_scheduler #(
    parameter int MIN_REPEAT   = 1,
    parameter int STALE_FRAMES = 255,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_complete,
    input  logic                 loaded,
    output logic                 flip,
    output logic                 ready,
    output logic                 pending,
    output logic                 stale,
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] stat_flips,
    output logic [CNT_WIDTH-1:0] stat_overruns
);
    localparam int SHW = $clog2(MIN_REPEAT + 1);
    localparam int STW = (STALE_FRAMES > 0) ? $clog2(STALE_FRAMES + 1) : 1;
    localparam logic [SHW-1:0] SH_MAX = SHW'(MIN_REPEAT);
    localparam logic [STW-1:0] ST_MAX = STW'(STALE_FRAMES);

    typedef enum logic {
        LOADING = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [SHW-1:0] shown_cnt;
    logic [STW-1:0] stale_cnt;
    logic           avail;
    logic           repeat_ok;
    logic           swap;
    logic           overrun;

    // A frame loaded in the same cycle as a boundary can be swapped straight in.
    assign avail     = (state_q == PENDING) || loaded;
    assign repeat_ok = (int'(shown_cnt) + 1) >= MIN_REPEAT;
    assign swap      = frame_complete && repeat_ok && avail;
    assign overrun   = loaded && (state_q == PENDING);

    always_comb begin
        state_d = state_q;
        if (swap)
            state_d = LOADING;
        else if ((state_q == LOADING) && loaded)
            state_d = PENDING;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= LOADING;
        else
            state_q <= state_d;
    end

    assign ready   = (state_q == LOADING);
    assign pending = (state_q == PENDING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip      <= 1'b0;
            shown_cnt <= '0;
        end else if (swap) begin
            flip      <= ~flip;
            shown_cnt <= '0;
        end else if (frame_complete && (shown_cnt != SH_MAX)) begin
            shown_cnt <= shown_cnt + 1'b1;
        end
    end

    // stale is set on the same edge that brings stale_cnt to its limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (swap) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (frame_complete && (STALE_FRAMES != 0)) begin
            if (stale_cnt != ST_MAX)
                stale_cnt <= stale_cnt + 1'b1;
            if ((int'(stale_cnt) + 1) >= STALE_FRAMES)
                stale <= 1'b1;
        end
    end

`ifdef FLIP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flips    <= '0;
            stat_overruns <= '0;
        end else if (stat_clr) begin
            stat_flips    <= '0;
            stat_overruns <= '0;
        end else begin
            if (swap && (stat_flips != '1))
                stat_flips <= stat_flips + 1'b1;
            if (overrun && (stat_overruns != '1))
                stat_overruns <= stat_overruns + 1'b1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats  = stat_clr ^ overrun;
    assign stat_flips    = '0;
    assign stat_overruns = '0;
`endif

endmodule

// File: tb/tb_frame_flip_scheduler.sv
// Bench for frame_flip_scheduler: two instances (MIN_REPEAT=1/STALE=4 and MIN_REPEAT=3/STALE off),
// table-driven vectors through a scoreboard queue plus hand-written reset and latency sequences.
module tb_frame_flip_scheduler;
`ifdef FLIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_fc, a_ld, a_clr, b_fc, b_ld, b_clr;
    logic        a_flip, a_ready, a_pend, a_stale;
    logic        b_flip, b_ready, b_pend, b_stale;
    logic [15:0] a_flips, a_ovr, b_flips, b_ovr;

    always #5 clk = ~clk;

    frame_flip_scheduler #(.MIN_REPEAT(1), .STALE_FRAMES(4), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .frame_complete(a_fc), .loaded(a_ld),
        .flip(a_flip), .ready(a_ready), .pending(a_pend), .stale(a_stale),
        .stat_clr(a_clr), .stat_flips(a_flips), .stat_overruns(a_ovr)
    );

    frame_flip_scheduler #(.MIN_REPEAT(3), .STALE_FRAMES(0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .frame_complete(b_fc), .loaded(b_ld),
        .flip(b_flip), .ready(b_ready), .pending(b_pend), .stale(b_stale),
        .stat_clr(b_clr), .stat_flips(b_flips), .stat_overruns(b_ovr)
    );

    typedef struct {
        bit          sel;
        bit          fc, ld, clr;
        bit          flip, ready, pend, stale;
        logic [15:0] flips, ovr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    function automatic vec_t mk(bit sel, bit fc, bit ld, bit clr, bit flip, bit ready,
                                bit pend, bit stale, int flips, int ovr);
        vec_t v;
        v.sel = sel; v.fc = fc; v.ld = ld; v.clr = clr;
        v.flip = flip; v.ready = ready; v.pend = pend; v.stale = stale;
        v.flips = 16'(flips); v.ovr = 16'(ovr);
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(string tag, vec_t e);
        logic [15:0] ef, eo;
        ef = STATS ? e.flips : 16'd0;
        eo = STATS ? e.ovr : 16'd0;
        if (!e.sel) begin
            check({tag, " a.flip"}, {15'd0, a_flip}, {15'd0, e.flip});
            check({tag, " a.ready"}, {15'd0, a_ready}, {15'd0, e.ready});
            check({tag, " a.pending"}, {15'd0, a_pend}, {15'd0, e.pend});
            check({tag, " a.stale"}, {15'd0, a_stale}, {15'd0, e.stale});
            check({tag, " a.stat_flips"}, a_flips, ef);
            check({tag, " a.stat_overruns"}, a_ovr, eo);
        end else begin
            check({tag, " b.flip"}, {15'd0, b_flip}, {15'd0, e.flip});
            check({tag, " b.ready"}, {15'd0, b_ready}, {15'd0, e.ready});
            check({tag, " b.pending"}, {15'd0, b_pend}, {15'd0, e.pend});
            check({tag, " b.stale"}, {15'd0, b_stale}, {15'd0, e.stale});
            check({tag, " b.stat_flips"}, b_flips, ef);
            check({tag, " b.stat_overruns"}, b_ovr, eo);
        end
    endtask

    // Called at a negedge: drive one cycle of pulses, check the registered result a cycle later.
    task automatic apply(vec_t v);
        vec_t e;
        a_fc = 1'b0; a_ld = 1'b0; a_clr = 1'b0;
        b_fc = 1'b0; b_ld = 1'b0; b_clr = 1'b0;
        if (!v.sel) begin
            a_fc = v.fc; a_ld = v.ld; a_clr = v.clr;
        end else begin
            b_fc = v.fc; b_ld = v.ld; b_clr = v.clr;
        end
        sb.push_back(v);
        @(negedge clk);
        a_fc = 1'b0; a_ld = 1'b0; a_clr = 1'b0;
        b_fc = 1'b0; b_ld = 1'b0; b_clr = 1'b0;
        step_no++;
        e = sb.pop_front();
        compare($sformatf("step%0d", step_no), e);
    endtask

    initial begin
        rst = 1'b1;
        a_fc = 1'b0; a_ld = 1'b0; a_clr = 1'b0;
        b_fc = 1'b0; b_ld = 1'b0; b_clr = 1'b0;

        //       sel fc ld clr flip rdy pend stale flips ovr
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1));  // overrun ignored
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 1));  // swap from pending
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 2, 1));  // direct swap, ready stays
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 2, 1));  // 4th frame -> stale
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 2, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 2, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 3, 2));  // swap + overrun
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0));  // clear
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0));  // clear beats events
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0));  // MIN_REPEAT=3
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 0));  // stale disabled
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 2, 0));  // shown_cnt saturated
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 2, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare("reset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        compare("reset", mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // loaded at cycle 10, frame_complete at cycle 20
        for (int i = 0; i < 9; i++) apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 9; i++) apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 0));

        // async reset while pending, no clock edge in between
        apply(mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0));
        #2 rst = 1'b1;
        #1 compare("async_rst", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
